// File: rtl/pr_opunit_if.sv
// pr_opunit_if: controller-to-datapath bus carrying operands, microop strobes and flags
interface pr_opunit_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i_din_a;
  logic [WIDTH-1:0] i_din_b;
  logic i_t1, i_t2, i_t3, i_t4, i_t5, i_t6, i_t7, i_t8, i_t9;
  logic o_x;
  logic o_y;
  logic [WIDTH-1:0] o_result;
  logic o_result_valid;
  modport master (
    output i_din_a, i_din_b, i_t1, i_t2, i_t3, i_t4, i_t5, i_t6, i_t7, i_t8, i_t9,
    input  o_x, o_y, o_result, o_result_valid
  );
  modport slave (
    input  i_din_a, i_din_b, i_t1, i_t2, i_t3, i_t4, i_t5, i_t6, i_t7, i_t8, i_t9,
    output o_x, o_y, o_result, o_result_valid
  );
endinterface

// File: rtl/pr_opunit.sv
// pr_opunit: datapath executing microoperations t1..t9 and returning flags x/y to the controller
module pr_opunit #(
  parameter int WIDTH    = 8,
  parameter int CW       = 4,
  parameter int CNT_INIT = 8
) (
  input logic clk,
  input logic res,
  pr_opunit_if.slave bus
);
  logic [WIDTH-1:0] r_ra, r_rb, r_result;
  logic             r_c, r_valid;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_ca;
  logic [WIDTH-1:0] w_rb;
  logic [CW-1:0]    w_cnt;
  always_comb begin
    w_ca  = bus.i_t3 ? {1'b0, bus.i_din_a} :
            bus.i_t1 ? {1'b0, r_ra} + {1'b0, r_rb} :
            bus.i_t9 ? {1'b0, r_ra} - {1'b0, r_rb} :
            bus.i_t5 ? {1'b0, r_c, r_ra[WIDTH-1:1]} : {r_c, r_ra};
    w_rb  = bus.i_t4 ? bus.i_din_b : bus.i_t6 ? {r_rb[WIDTH-2:0], 1'b0} : r_rb;
    w_cnt = bus.i_t7 ? CW'(CNT_INIT) : (bus.i_t2 && r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      r_ra     <= '0;
      r_rb     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      {r_c, r_ra} <= w_ca;
      r_rb        <= w_rb;
      r_cnt       <= w_cnt;
      r_result    <= bus.i_t8 ? r_ra : r_result;
      r_valid     <= bus.i_t8;
    end
  end
  assign bus.o_x            = (r_cnt == '0);
  assign bus.o_y            = r_ra[0];
  assign bus.o_result       = r_result;
  assign bus.o_result_valid = r_valid;
endmodule

// File: tb/tb_pr_opunit.sv
// tb_pr_opunit: scoreboard bench for pr_opunit with directed vectors
module tb_pr_opunit;
  localparam logic [8:0] T1 = 9'h001, T2 = 9'h002, T3 = 9'h004, T4 = 9'h008, T5 = 9'h010,
                         T6 = 9'h020, T7 = 9'h040, T8 = 9'h080, T9 = 9'h100, T0 = 9'h000;
  typedef struct packed {
    logic       x;
    logic       y;
    logic       v;
    logic [7:0] r;
  } exp_t;
  logic clk = 1'b0;
  logic res;
  logic done = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [7:0] rq[$];
  exp_t       fq[$];
  pr_opunit_if #(.WIDTH(8)) u ();
  pr_opunit #(.WIDTH(8), .CW(4), .CNT_INIT(8)) dut (.clk(clk), .res(res), .bus(u));
  always #5 clk = ~clk;
  task automatic drive(input logic r, input logic [8:0] t, input logic [7:0] a, input logic [7:0] b);
    res       = r;
    u.i_t1    = t[0];
    u.i_t2    = t[1];
    u.i_t3    = t[2];
    u.i_t4    = t[3];
    u.i_t5    = t[4];
    u.i_t6    = t[5];
    u.i_t7    = t[6];
    u.i_t8    = t[7];
    u.i_t9    = t[8];
    u.i_din_a = a;
    u.i_din_b = b;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic [8:0] t, input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00);
    drive(1'b0, t, a, b);
  endtask
  task automatic expect_st(input logic x, input logic y, input logic v, input logic [7:0] r);
    fq.push_back('{x: x, y: y, v: v, r: r});
  endtask
  always @(negedge clk) begin
    if (u.o_result_valid === 1'b1) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fails++;
        $display("FAIL result_pulse: result_valid high with result=%02h but no t8 outstanding", u.o_result);
      end else begin
        logic [7:0] e;
        e = rq.pop_front();
        if (u.o_result !== e) begin
          n_fails++;
          $display("FAIL result_data: got %02h want %02h", u.o_result, e);
        end
      end
    end
    if (fq.size() != 0) begin
      exp_t e;
      e = fq.pop_front();
      n_checks += 4;
      if (u.o_x !== e.x) begin
        n_fails++;
        $display("FAIL flag_x: got %b want %b at %0t", u.o_x, e.x, $time);
      end
      if (u.o_y !== e.y) begin
        n_fails++;
        $display("FAIL flag_y: got %b want %b at %0t", u.o_y, e.y, $time);
      end
      if (u.o_result_valid !== e.v) begin
        n_fails++;
        $display("FAIL result_valid: got %b want %b at %0t", u.o_result_valid, e.v, $time);
      end
      if (u.o_result !== e.r) begin
        n_fails++;
        $display("FAIL result_reg: got %02h want %02h at %0t", u.o_result, e.r, $time);
      end
    end
    if (done) begin
      n_checks++;
      if (rq.size() != 0) begin
        n_fails++;
        $display("FAIL result_missing: %0d t8 results never presented, want 0", rq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion before 200000");
    $fatal(1, "timeout");
  end
  initial begin
    drive(1'b1, 9'($urandom), 8'($urandom), 8'($urandom));
    expect_st(1, 0, 0, 8'h00);
    step(T1);
    step(T5);
    rq.push_back(8'h00);
    step(T8);
    expect_st(1, 0, 1, 8'h00);
    step(T0);
    expect_st(1, 0, 0, 8'h00);
    step(T3 | T4, 8'hF0, 8'h20);
    expect_st(1, 0, 0, 8'h00);
    step(T1);
    step(T5);
    expect_st(1, 0, 0, 8'h00);
    rq.push_back(8'h88);
    step(T8);
    expect_st(1, 0, 1, 8'h88);
    step(T3 | T4, 8'h05, 8'h07);
    step(T9);
    expect_st(1, 0, 0, 8'h88);
    rq.push_back(8'hFE);
    step(T8);
    step(T5);
    expect_st(1, 1, 0, 8'hFE);
    rq.push_back(8'hFF);
    step(T8);
    expect_st(1, 1, 1, 8'hFF);
    step(T3 | T4, 8'h07, 8'h05);
    step(T9);
    rq.push_back(8'h02);
    step(T5 | T8);
    expect_st(1, 1, 1, 8'h02);
    rq.push_back(8'h01);
    step(T8);
    expect_st(1, 1, 1, 8'h01);
    step(T0);
    expect_st(1, 1, 0, 8'h01);
    step(T7);
    expect_st(0, 1, 0, 8'h01);
    for (int i = 1; i <= 9; i++) begin
      step(T2);
      expect_st(i >= 8, 1, 0, 8'h01);
    end
    step(T7 | T2);
    expect_st(0, 1, 0, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      step(T2);
      expect_st(i == 8, 1, 0, 8'h01);
    end
    step(T3 | T4, 8'hFF, 8'h01);
    step(T1);
    step(T3 | T1 | T5, 8'h55);
    expect_st(1, 1, 0, 8'h01);
    step(T4 | T6, 8'h00, 8'h03);
    rq.push_back(8'h55);
    step(T8);
    step(T5);
    rq.push_back(8'h2A);
    step(T8);
    step(T1);
    rq.push_back(8'h2D);
    step(T8);
    step(T1 | T9 | T5);
    rq.push_back(8'h30);
    step(T9 | T5 | T8);
    rq.push_back(8'h2D);
    step(T8);
    step(T6);
    step(T9);
    rq.push_back(8'h27);
    step(T8);
    expect_st(1, 1, 1, 8'h27);
    step(T3, 8'h3C);
    rq.push_back(8'h3C);
    step(T8 | T3, 8'h11);
    expect_st(1, 1, 1, 8'h3C);
    step(T0);
    expect_st(1, 1, 0, 8'h3C);
    rq.push_back(8'h11);
    step(T8);
    step(T3 | T4, 8'hF1, 8'h20);
    step(T7);
    step(T1 | T2);
    drive(1'b1, T1 | T2, 8'h00, 8'h00);
    expect_st(1, 0, 0, 8'h00);
    step(T1 | T2);
    expect_st(1, 0, 0, 8'h00);
    step(T5);
    rq.push_back(8'h00);
    step(T8);
    expect_st(1, 0, 1, 8'h00);
    step(T0);
    step(T0);
    done = 1'b1;
  end
endmodule
